// File: rtl/interpo_coef_reader_if.sv
// Bus bundle for the coefficient reader: run control, Avalon-MM read port to the
// coefficient RAM, and the sop/eop framed coefficient stream.
interface interpo_coef_reader_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6
);
   logic              start;
   logic [ADDR_W-1:0] start_base;
   logic [ADDR_W:0]   start_count;
   logic              abort;
   logic              busy;
   logic              done;
   logic              err;

   logic [ADDR_W-1:0] m_address;
   logic              m_chipselect;
   logic [3:0]        m_byteenable;
   logic              m_write;
   logic [DATA_W-1:0] m_readdata;

   logic [DATA_W-1:0] coef_data;
   logic              coef_valid;
   logic              coef_ready;
   logic              coef_sop;
   logic              coef_eop;

   modport master (
      input  start, start_base, start_count, abort, m_readdata, coef_ready,
      output busy, done, err, m_address, m_chipselect, m_byteenable, m_write,
             coef_data, coef_valid, coef_sop, coef_eop
   );

   modport slave (
      output start, start_base, start_count, abort, m_readdata, coef_ready,
      input  busy, done, err, m_address, m_chipselect, m_byteenable, m_write,
             coef_data, coef_valid, coef_sop, coef_eop
   );
endinterface

// File: rtl/interpo_coef_reader.sv
// Avalon-MM read master: fetches a wrapped run of coefficients from the RAM and
// streams them out through a small first-word-fall-through buffer with sop/eop framing.
module interpo_coef_reader #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 6,
   parameter int DEPTH        = 40,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input logic                   clk,
   input logic                   reset_n,
   interpo_coef_reader_if.master bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [1:0]              state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [ADDR_W:0]         count_q, count_d;
   logic [ADDR_W:0]         issued_q, issued_d;
   logic [ADDR_W:0]         out_idx_q, out_idx_d;
   logic [CNT_W-1:0]        inflight_q, inflight_d;
   logic [READ_LATENCY-1:0] ret_pipe_q;
   logic [PTR_W:0]          wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]          rd_ptr_q, rd_ptr_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [DATA_W-1:0]       fifo_mem [FIFO_DEPTH];

   logic              run;
   logic              ret_vld;
   logic [CNT_W-1:0]  fifo_used;
   logic              fifo_empty;
   logic              issue;
   logic              push;
   logic              pop;
   logic              xfer;
   logic              is_eop;
   logic [DATA_W-1:0] head;
   logic [ADDR_W:0]   clamped_count;

   assign run        = (state_q == S_RUN);
   assign ret_vld    = ret_pipe_q[READ_LATENCY-1];
   assign fifo_used  = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (fifo_used == '0);

   // Words buffered plus words still in the RAM pipe never exceed the buffer size,
   // so every returning word is guaranteed a slot.
   assign issue = run && !bus.abort && (issued_q < count_q) &&
                  (({1'b0, fifo_used} + {1'b0, inflight_q}) < (CNT_W+1)'(FIFO_DEPTH));

   // Returning data is presented directly when the buffer is empty.
   assign bus.coef_valid = run && (!fifo_empty || ret_vld);
   assign head           = fifo_empty ? bus.m_readdata : fifo_mem[rd_ptr_q[PTR_W-1:0]];
   assign xfer           = bus.coef_valid && bus.coef_ready;
   assign push           = run && ret_vld && !(fifo_empty && bus.coef_ready);
   assign pop            = run && !fifo_empty && bus.coef_ready;
   assign is_eop         = (out_idx_q == count_q - (ADDR_W+1)'(1));

   assign clamped_count = (bus.start_count > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH)
                                                                : bus.start_count;

   // NOTE: every signal written here gets a default first so no path infers a latch.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      count_d    = count_q;
      issued_d   = issued_q;
      out_idx_d  = out_idx_q;
      wr_ptr_d   = wr_ptr_q + (PTR_W+1)'(push);
      rd_ptr_d   = rd_ptr_q + (PTR_W+1)'(pop);
      inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(ret_vld);
      done_d     = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if ({1'b0, bus.start_base} >= (ADDR_W+1)'(DEPTH)) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else if (bus.start_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d   = S_RUN;
                  addr_d    = bus.start_base;
                  count_d   = clamped_count;
                  issued_d  = '0;
                  out_idx_d = '0;
               end
            end
         end

         S_RUN: begin
            if (issue) begin
               issued_d = issued_q + (ADDR_W+1)'(1);
               addr_d   = (addr_q == ADDR_W'(DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);
            end
            if (xfer) out_idx_d = out_idx_q + (ADDR_W+1)'(1);

            // The eop transfer takes precedence over a simultaneous abort.
            if (xfer && is_eop) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else if (bus.abort) begin
               state_d  = S_FLUSH;
               wr_ptr_d = '0;
               rd_ptr_d = '0;
            end
         end

         S_FLUSH: begin
            if (inflight_q == '0) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               err_d   = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         count_q    <= '0;
         issued_q   <= '0;
         out_idx_q  <= '0;
         inflight_q <= '0;
         ret_pipe_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         issued_q   <= issued_d;
         out_idx_q  <= out_idx_d;
         inflight_q <= inflight_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ret_pipe_q[0] <= issue;
         for (int i = 1; i < READ_LATENCY; i++) ret_pipe_q[i] <= ret_pipe_q[i-1];
      end
   end

   // NOTE: buffer storage is not reset; the pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= bus.m_readdata;
   end

   assign bus.busy         = (state_q != S_IDLE);
   assign bus.done         = done_q;
   assign bus.err          = err_q;
   assign bus.m_address    = addr_q;
   assign bus.m_chipselect = issue;
   assign bus.m_byteenable = 4'hF;
   assign bus.m_write      = 1'b0;
   assign bus.coef_data    = bus.coef_valid ? head : '0;
   assign bus.coef_sop     = bus.coef_valid && (out_idx_q == '0);
   assign bus.coef_eop     = bus.coef_valid && is_eop;
endmodule

// File: tb/tb_interpo_coef_reader.sv
// Directed bench for interpo_coef_reader: RAM model behind the read port and a
// scoreboard of expected addresses and stream words filled when each run starts.
module tb_interpo_coef_reader;
   localparam int DATA_W       = 32;
   localparam int ADDR_W       = 6;
   localparam int DEPTH        = 40;
   localparam int READ_LATENCY = 1;
   localparam int FIFO_DEPTH   = 4;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              sop;
      logic              eop;
   } word_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   interpo_coef_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   interpo_coef_reader #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
      .READ_LATENCY(READ_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   logic [DATA_W-1:0] ram [DEPTH];
   initial for (int i = 0; i < DEPTH; i++) ram[i] = {16'hC0EF, 8'(i * 7 + 3), 8'(i)};

   always @(posedge clk)
      if (bus.m_chipselect)
         bus.m_readdata <= (bus.m_address < ADDR_W'(DEPTH)) ? ram[bus.m_address] : 'x;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   word_t             exp_q[$];
   logic [ADDR_W-1:0] addr_q[$];
   int    n_strobe, n_xfer;
   int    start_cyc, first_valid_cyc, sop_cyc, eop_cyc, done_cyc;
   logic  done_seen, done_err, occ_chk, held;
   word_t held_word;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Samples the DUT 1ns after the inputs were driven, then waits for the next negedge.
   task automatic tick();
      word_t cur;
      #1;
      cur = '{data: bus.coef_data, sop: bus.coef_sop, eop: bus.coef_eop};
      if (bus.m_chipselect) begin
         if (occ_chk) check("occupancy", 64'(n_strobe - n_xfer < FIFO_DEPTH), 64'(1));
         if (addr_q.size() == 0) check("strobe_expected", 64'(addr_q.size()), 64'(1));
         else check("m_address", 64'(bus.m_address), 64'(addr_q.pop_front()));
         n_strobe++;
      end
      if (bus.coef_valid && held) check("stall_stable", 64'(cur), 64'(held_word));
      held      = bus.coef_valid && !bus.coef_ready;
      held_word = cur;
      if (bus.coef_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.coef_valid && bus.coef_ready) begin
         n_xfer++;
         if (cur.sop) sop_cyc = cyc;
         if (cur.eop) eop_cyc = cyc;
         if (exp_q.size() == 0) check("word_expected", 64'(exp_q.size()), 64'(1));
         else check("coef_word", 64'(cur), 64'(exp_q.pop_front()));
      end
      if (bus.done) begin
         done_seen = 1'b1;
         done_err  = bus.err;
         done_cyc  = cyc;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic start_run(input int base, input int count);
      int n;
      n = (count > DEPTH) ? DEPTH : count;
      if (base < DEPTH)
         for (int i = 0; i < n; i++) begin
            int a;
            a = (base + i) % DEPTH;
            addr_q.push_back(ADDR_W'(a));
            exp_q.push_back('{data: ram[a], sop: (i == 0), eop: (i == n - 1)});
         end
      n_strobe = 0; n_xfer = 0; held = 1'b0; done_seen = 1'b0;
      first_valid_cyc = -1; sop_cyc = -1; eop_cyc = -1; done_cyc = -1;
      bus.start       = 1'b1;
      bus.start_base  = ADDR_W'(base);
      bus.start_count = (ADDR_W+1)'(count);
      start_cyc       = cyc;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && !done_seen; i++) tick();
      check("done_seen", 64'(done_seen), 64'(1));
   endtask

   task automatic check_drained(input string tag);
      check({tag, "_words_left"}, 64'(exp_q.size()), 64'(0));
      check({tag, "_addrs_left"}, 64'(addr_q.size()), 64'(0));
   endtask

   initial begin
      bus.start = 1'b0; bus.start_base = '0; bus.start_count = '0;
      bus.abort = 1'b0; bus.coef_ready = 1'b0;
      occ_chk = 1'b1; held = 1'b0; done_seen = 1'b0;
      n_strobe = 0; n_xfer = 0;

      // Reset state
      @(negedge clk);
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_done", 64'(bus.done), 64'(0));
      check("rst_err", 64'(bus.err), 64'(0));
      check("rst_cs", 64'(bus.m_chipselect), 64'(0));
      check("rst_addr", 64'(bus.m_address), 64'(0));
      check("rst_be", 64'(bus.m_byteenable), 64'hF);
      check("rst_write", 64'(bus.m_write), 64'(0));
      check("rst_valid", 64'(bus.coef_valid), 64'(0));
      check("rst_sop_eop", 64'({bus.coef_sop, bus.coef_eop}), 64'(0));
      check("rst_data", 64'(bus.coef_data), 64'(0));
      reset_n = 1'b1;
      tick();

      // Full table at full rate
      bus.coef_ready = 1'b1;
      start_run(0, 40);
      wait_done(100);
      check("full_first_valid_lat", 64'(first_valid_cyc - start_cyc), 64'(READ_LATENCY + 1));
      check("full_throughput", 64'(eop_cyc - sop_cyc), 64'(39));
      check("full_done_lat", 64'(done_cyc - eop_cyc), 64'(1));
      check("full_err", 64'(done_err), 64'(0));
      check("full_words", 64'(n_xfer), 64'(40));
      check("full_busy_after", 64'(bus.busy), 64'(0));
      check_drained("full");

      // Wrap 38,39,0,1
      start_run(38, 4);
      wait_done(30);
      check("wrap_err", 64'(done_err), 64'(0));
      check_drained("wrap");

      // Ready toggling every cycle
      start_run(12, 5);
      for (int i = 0; i < 60 && !done_seen; i++) begin
         bus.coef_ready = ~bus.coef_ready;
         tick();
      end
      check("toggle_done", 64'(done_seen), 64'(1));
      check("toggle_err", 64'(done_err), 64'(0));
      check("toggle_words", 64'(n_xfer), 64'(5));
      check_drained("toggle");
      bus.coef_ready = 1'b1;
      tick();

      // Empty run
      start_run(5, 0);
      wait_done(10);
      check("zero_done_lat", 64'(done_cyc - start_cyc), 64'(1));
      check("zero_err", 64'(done_err), 64'(0));
      check("zero_strobes", 64'(n_strobe), 64'(0));

      // Bad base
      start_run(45, 3);
      wait_done(10);
      check("badbase_done_lat", 64'(done_cyc - start_cyc), 64'(1));
      check("badbase_err", 64'(done_err), 64'(1));
      check("badbase_strobes", 64'(n_strobe), 64'(0));

      // Oversized count clamps to the table depth
      start_run(10, 64);
      wait_done(100);
      check("clamp_words", 64'(n_xfer), 64'(DEPTH));
      check("clamp_err", 64'(done_err), 64'(0));
      check_drained("clamp");

      // Abort after three reads with the stream stalled
      bus.coef_ready = 1'b0;
      start_run(3, 10);
      for (int i = 0; i < 20 && n_strobe < 3; i++) tick();
      check("abort_strobes", 64'(n_strobe), 64'(3));
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      exp_q.delete();
      addr_q.delete();
      check("abort_valid_drop", 64'(bus.coef_valid), 64'(0));
      check("abort_busy_flush", 64'(bus.busy), 64'(1));
      wait_done(20);
      check("abort_err", 64'(done_err), 64'(1));
      check("abort_busy_after", 64'(bus.busy), 64'(0));
      check("abort_no_xfer", 64'(n_xfer), 64'(0));
      bus.coef_ready = 1'b1;
      tick();

      // Abort coinciding with the single (sop+eop) word transfer
      start_run(7, 1);
      tick();
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      wait_done(10);
      check("abort_eop_err", 64'(done_err), 64'(0));
      check("abort_eop_words", 64'(n_xfer), 64'(1));
      check_drained("abort_eop");

      // Asynchronous reset mid-run, then a clean new run
      start_run(0, 20);
      for (int i = 0; i < 5; i++) tick();
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_busy", 64'(bus.busy), 64'(0));
      check("arst_valid", 64'(bus.coef_valid), 64'(0));
      check("arst_cs", 64'(bus.m_chipselect), 64'(0));
      check("arst_done", 64'(bus.done), 64'(0));
      check("arst_data", 64'(bus.coef_data), 64'(0));
      @(negedge clk);
      exp_q.delete();
      addr_q.delete();
      reset_n = 1'b1;
      tick();
      start_run(20, 3);
      wait_done(30);
      check("post_rst_first_valid_lat", 64'(first_valid_cyc - start_cyc), 64'(READ_LATENCY + 1));
      check("post_rst_err", 64'(done_err), 64'(0));
      check("post_rst_words", 64'(n_xfer), 64'(3));
      check_drained("post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit reached");
   end
endmodule
